// File: rtl/cntry_car_sensor.sv
// Country-road loop sensor front end: sync + debounce, waiting-car queue, request x.
// Define CNT_SENSOR_OVF_EN to build the sticky overflow register (otherwise overflow is 0).
module cntry_car_sensor #(
   parameter int DEBOUNCE    = 3,
   parameter int CNT_W       = 4,
   parameter int PASS_CYCLES = 2
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             loop_in,
   input  logic [1:0]       cntry,
   output logic             x,
   output logic [CNT_W-1:0] queue_cnt,
   output logic             overflow
);

   localparam logic [1:0] GREEN    = 2'd2;
   localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);
   localparam int         PT_W     = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
   localparam logic [PT_W-1:0] PT_LAST = PT_W'(PASS_CYCLES - 1);

   typedef enum logic [2:0] {
      EMPTY    = 3'd0,
      RISE_CHK = 3'd1,
      PRESENT  = 3'd2,
      FALL_CHK = 3'd3
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic             s1, s2;
   state_t           state, state_nxt;
   logic [3:0]       deb, deb_nxt;
   logic             arrive, depart, green_q, pass_en, full;
   logic [PT_W-1:0]  ptmr;
   logic [CNT_W-1:0] q_nxt;

   // Input stage: two-flop synchroniser, light state captured alongside
   always_ff @(posedge clock) begin
      if (clear) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         green_q <= 1'b0;
      end else begin
         s1      <= loop_in;
         s2      <= s1;
         green_q <= (cntry == GREEN);
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= EMPTY;
         deb   <= 4'd0;
      end else begin
         state <= state_nxt;
         deb   <= deb_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      deb_nxt   = deb;
      case (state)
         EMPTY: begin
            if (s2) begin
               state_nxt = RISE_CHK;
               deb_nxt   = 4'd1;
            end
         end
         RISE_CHK: begin
            if (!s2) begin
               state_nxt = EMPTY;
               deb_nxt   = 4'd0;
            end else if (deb == DEB_LAST) begin
               state_nxt = PRESENT;
            end else begin
               deb_nxt = deb + 4'd1;
            end
         end
         PRESENT: begin
            if (!s2) begin
               state_nxt = FALL_CHK;
               deb_nxt   = 4'd1;
            end
         end
         FALL_CHK: begin
            if (s2) begin
               state_nxt = PRESENT;
            end else if (deb == DEB_LAST) begin
               state_nxt = EMPTY;
               deb_nxt   = 4'd0;
            end else begin
               deb_nxt = deb + 4'd1;
            end
         end
         default: begin
            state_nxt = EMPTY;
            deb_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      arrive = (state == RISE_CHK) && s2 && (deb == DEB_LAST);
   end

   // A car leaves only after PASS_CYCLES uninterrupted GREEN cycles with a non-empty queue
   assign pass_en = green_q && (queue_cnt != '0);
   assign depart  = pass_en && (ptmr == PT_LAST);
   assign full    = &queue_cnt;

   always_ff @(posedge clock) begin
      if (clear)
         ptmr <= '0;
      else if (!pass_en || depart)
         ptmr <= '0;
      else
         ptmr <= ptmr + PT_W'(1);
   end

   always_comb begin
      q_nxt = queue_cnt;
      if (arrive && !depart)
         q_nxt = sat_inc(queue_cnt);
      else if (depart && !arrive)
         q_nxt = queue_cnt - CNT_W'(1);
   end

   // Queue stage: x is derived from the same next value so both move together
   always_ff @(posedge clock) begin
      if (clear) begin
         queue_cnt <= '0;
         x         <= 1'b0;
      end else begin
         queue_cnt <= q_nxt;
         x         <= (q_nxt != '0);
      end
   end

`ifdef CNT_SENSOR_OVF_EN
   logic ovf_q;

   always_ff @(posedge clock) begin
      if (clear)
         ovf_q <= 1'b0;
      else if (arrive && !depart && full)
         ovf_q <= 1'b1;
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cntry_car_sensor.sv
// Bench for cntry_car_sensor: segment table, saturation/clear sequence, random traffic vs model.
module tb_cntry_car_sensor;

   localparam int DEBOUNCE    = 3;
   localparam int CNT_W       = 4;
   localparam int PASS_CYCLES = 2;
   localparam int QMAX        = (1 << CNT_W) - 1;
   localparam logic [1:0] R = 2'd0, Y = 2'd1, G = 2'd2;
`ifdef CNT_SENSOR_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             clear = 1'b1;
   logic             loop_in = 1'b0;
   logic [1:0]       cntry = 2'd0;
   logic             x;
   logic [CNT_W-1:0] queue_cnt;
   logic             overflow;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   cntry_car_sensor #(
      .DEBOUNCE(DEBOUNCE),
      .CNT_W(CNT_W),
      .PASS_CYCLES(PASS_CYCLES)
   ) dut (
      .clock(clock),
      .clear(clear),
      .loop_in(loop_in),
      .cntry(cntry),
      .x(x),
      .queue_cnt(queue_cnt),
      .overflow(overflow)
   );

   // Reference model: accepted loop level flips after DEBOUNCE consecutive disagreeing
   // samples of the twice-delayed input; one car leaves per PASS_CYCLES run of GREEN.
   bit m_h1, m_h2, m_lvl, m_gq, m_ovf;
   int m_run, m_grun, m_q;

   task automatic model_edge(input logic c, input logic l, input logic [1:0] cn);
      bit arr, dep, s2v;
      if (c) begin
         m_h1 = 0; m_h2 = 0; m_lvl = 0; m_gq = 0; m_ovf = 0;
         m_run = 0; m_grun = 0; m_q = 0;
      end else begin
         s2v = m_h2;
         arr = 0;
         if (s2v != m_lvl) begin
            m_run++;
            if (m_run == DEBOUNCE) begin
               m_lvl = s2v;
               m_run = 0;
               arr   = s2v;
            end
         end else begin
            m_run = 0;
         end
         dep = 0;
         if (m_gq && m_q > 0) begin
            m_grun++;
            if (m_grun == PASS_CYCLES) begin
               dep    = 1;
               m_grun = 0;
            end
         end else begin
            m_grun = 0;
         end
         if (arr && !dep) begin
            if (m_q == QMAX) m_ovf = OVF_ON;
            else m_q++;
         end else if (dep && !arr) begin
            m_q--;
         end
         m_h2 = m_h1;
         m_h1 = l;
         m_gq = (cn == G);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic c, input logic l, input logic [1:0] cn);
      clear   = c;
      loop_in = l;
      cntry   = cn;
      @(posedge clock);
      model_edge(c, l, cn);
      #1;
      check("model_queue_cnt", queue_cnt, m_q);
      check("model_x", x, (m_q != 0));
      check("model_overflow", overflow, m_ovf);
   endtask

   typedef struct {
      logic       clr;
      logic       loop;
      logic [1:0] cn;
      int         n;
      int         eq;
      bit         eovf;
   } seg_t;

   seg_t segs[$];

   function automatic seg_t mk(input logic c, input logic l, input logic [1:0] cn,
                               input int n, input int eq);
      seg_t s;
      s.clr = c; s.loop = l; s.cn = cn; s.n = n; s.eq = eq; s.eovf = 1'b0;
      return s;
   endfunction

   initial begin
      int lhold, chold, ll, cc, eq;

      // reset with sensor high and GREEN, then first car 5 edges after release
      segs.push_back(mk(1, 1, G, 3, 0));
      segs.push_back(mk(0, 1, G, 4, 0));
      segs.push_back(mk(0, 1, R, 1, 1));
      segs.push_back(mk(0, 0, R, 8, 1));
      // 2-cycle glitch
      segs.push_back(mk(0, 1, R, 2, 1));
      segs.push_back(mk(0, 0, R, 6, 1));
      // second car, then 1-cycle dips inside the long high
      segs.push_back(mk(0, 1, R, 4, 1));
      segs.push_back(mk(0, 1, R, 1, 2));
      segs.push_back(mk(0, 0, R, 1, 2));
      segs.push_back(mk(0, 1, R, 3, 2));
      segs.push_back(mk(0, 0, R, 1, 2));
      segs.push_back(mk(0, 1, R, 3, 2));
      segs.push_back(mk(0, 0, R, 6, 2));
      segs.push_back(mk(0, 1, R, 4, 2));
      segs.push_back(mk(0, 1, R, 1, 3));
      segs.push_back(mk(0, 0, R, 6, 3));
      // discharge of 3 cars: edges e..e+6
      segs.push_back(mk(0, 0, G, 1, 3));
      segs.push_back(mk(0, 0, G, 1, 3));
      segs.push_back(mk(0, 0, G, 1, 2));
      segs.push_back(mk(0, 0, G, 2, 1));
      segs.push_back(mk(0, 0, G, 2, 0));
      segs.push_back(mk(0, 0, G, 3, 0));
      // interrupted discharge, then a fresh full count
      segs.push_back(mk(0, 1, R, 5, 1));
      segs.push_back(mk(0, 0, R, 6, 1));
      segs.push_back(mk(0, 0, G, 1, 1));
      segs.push_back(mk(0, 0, R, 3, 1));
      segs.push_back(mk(0, 0, G, 2, 1));
      segs.push_back(mk(0, 0, G, 1, 0));
      segs.push_back(mk(0, 0, R, 2, 0));
      // three cars, then arrival coinciding with a departure
      for (int k = 1; k <= 3; k++) begin
         segs.push_back(mk(0, 1, R, 5, k));
         segs.push_back(mk(0, 0, R, 6, k));
      end
      segs.push_back(mk(0, 1, G, 2, 3));
      segs.push_back(mk(0, 1, G, 1, 2));
      segs.push_back(mk(0, 1, G, 2, 2));
      segs.push_back(mk(0, 1, G, 1, 2));
      segs.push_back(mk(0, 1, G, 1, 1));
      segs.push_back(mk(0, 0, G, 4, 0));
      segs.push_back(mk(0, 0, R, 2, 0));

      foreach (segs[i]) begin
         repeat (segs[i].n) step(segs[i].clr, segs[i].loop, segs[i].cn);
         check($sformatf("tbl%0d_queue_cnt", i), queue_cnt, segs[i].eq);
         check($sformatf("tbl%0d_x", i), x, (segs[i].eq != 0));
         check($sformatf("tbl%0d_overflow", i), overflow, segs[i].eovf);
      end

      // saturation: 16 arrivals
      for (int i = 0; i < 16; i++) begin
         repeat (5) step(0, 1, R);
         repeat (6) step(0, 0, R);
         eq = (i + 1 > QMAX) ? QMAX : i + 1;
         check($sformatf("sat%0d_queue_cnt", i), queue_cnt, eq);
         check($sformatf("sat%0d_overflow", i), overflow, (i == 15) ? OVF_ON : 1'b0);
      end

      // clear mid-debounce
      repeat (3) step(0, 1, R);
      step(1, 1, R);
      check("clr_queue_cnt", queue_cnt, 0);
      check("clr_x", x, 0);
      check("clr_overflow", overflow, 0);
      repeat (8) step(0, 0, R);
      check("clr_no_stray", queue_cnt, 0);

      // random traffic
      lhold = 0; chold = 0; ll = 0; cc = 0;
      for (int i = 0; i < 3000; i++) begin
         if (lhold == 0) begin
            ll    = $urandom_range(0, 1);
            lhold = $urandom_range(1, 8);
         end
         if (chold == 0) begin
            case ($urandom_range(0, 4))
               0, 1:    cc = R;
               2:       cc = Y;
               default: cc = G;
            endcase
            chold = $urandom_range(1, 12);
         end
         lhold--;
         chold--;
         step(($urandom_range(0, 399) == 0), ll[0], cc[1:0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
